tm_window_sequencer: RTL
========================

Name: tm_window_sequencer

Overview:
Controls one window pass of the template-matching accumulator datapath, which computes the sum of I, the sum of I squared and the sum of T times I per template.
- Accepts image lines from an upstream source with a valid/ready handshake.
- Issues a clear pulse and then one accumulate-enable per line to the datapath.
- After NUM_OF_LINES lines, waits for the pipeline latency and captures the accumulator outputs.
- Presents the captured results on a valid/ready result port.
- Sits between the line source and the accumulator datapath, beside the top-level image/template line inputs.

Parameters:
PIXEL_SIZE, 8, pixel width in bits
LINE_SIZE, 8, pixels per line
NUM_OF_LINES, 8, lines per window (>=1)
NUM_TEMPLATES, 1, number of templates processed in parallel
ACC_LATENCY, 2, cycles from the acc_en sampling edge until the datapath sums reflect that line (>=0)
ACC_W (localparam), $clog2(NUM_OF_LINES)+$clog2(LINE_SIZE)+2*PIXEL_SIZE, accumulator width

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a window; sampled only in IDLE
abort  in  1  synchronous abandon of the current window
busy  out  1  high in any state other than IDLE
line_valid  in  1  upstream line available
line_ready  out  1  sequencer accepts a line
acc_clear  out  1  one-cycle clear to the datapath accumulators
acc_en  out  1  datapath samples the current line
line_idx  out  $clog2(NUM_OF_LINES) (min 1)  index of the line currently offered
acc_sum_I  in  ACC_W  datapath sum of I
acc_sum_I_sq  in  ACC_W  datapath sum of I squared
acc_sum_TxI  in  ACC_W*NUM_TEMPLATES  datapath sum of T times I; template t occupies bits [t*ACC_W +: ACC_W]
res_valid  out  1  captured results valid
res_ready  in  1  consumer accepts the results
res_sum_I  out  ACC_W  captured sum of I
res_sum_I_sq  out  ACC_W  captured sum of I squared
res_sum_TxI  out  ACC_W*NUM_TEMPLATES  captured sum of T times I, same packing as acc_sum_TxI

Behaviour:
Reset
- reset low forces state IDLE immediately, independent of CLK.
- All counters, result registers and registered outputs clear to 0.
- busy, line_ready, acc_clear, acc_en and res_valid are 0 while in reset.
- Reset asserted mid-window discards all progress.

IDLE
- busy=0, line_ready=0.
- start=1 moves to CLEAR on the next edge.

CLEAR
- acc_clear=1 for exactly this one cycle; line counter loads 0.
- Always moves to STREAM on the next edge.

STREAM
- line_ready=1.
- acc_en = line_valid & line_ready (combinational): exactly one acc_en per accepted line, and none without a handshake.
- line_idx equals the number of lines accepted so far in this window.
- Gaps in line_valid are allowed; the counter holds during gaps.
- On acceptance of line NUM_OF_LINES-1: load the drain counter with ACC_LATENCY and move to DRAIN.

DRAIN
- line_ready=0, acc_en=0.
- Count down each cycle. In the cycle the counter reads 0:
  - capture acc_sum_I, acc_sum_I_sq and acc_sum_TxI into the res_* registers;
  - set res_valid=1 on that edge;
  - move to DONE.
- The capture edge is ACC_LATENCY+1 edges after the last acc_en edge.

DONE
- res_* hold stable and res_valid holds at 1 until res_valid & res_ready.
- On that handshake: res_valid→0, move to IDLE. res_* keep their values.
- start is ignored in DONE, including in the handshake cycle.

Abort
- abort=1 in CLEAR, STREAM, DRAIN or DONE moves to IDLE on the next edge.
- res_valid→0; no capture; counters cleared.
- acc_en is forced to 0 in the abort cycle.
- abort has priority over start and over every handshake in the same cycle.
- abort in IDLE has no effect.

Widths
- No arithmetic is performed on the sums; they are captured verbatim.
- The line counter never exceeds NUM_OF_LINES-1.
- NUM_OF_LINES=1: CLEAR → STREAM → DRAIN after a single line.

Test Plan:
(All scenarios use LINE_SIZE=4, NUM_OF_LINES=4, PIXEL_SIZE=8, ACC_LATENCY=2, NUM_TEMPLATES=1, with the bench modelling the accumulator.)
1. Hold reset low for 3 cycles, then release → busy, line_ready, acc_clear, acc_en, res_valid and all res_* equal 0; one start gives one acc_clear pulse on the next cycle.
2. Continuous line_valid, every pixel I=1 and T=2 → 4 acc_en pulses with line_idx 0,1,2,3; res_valid rises 3 edges after the last acc_en; res_sum_I=16, res_sum_I_sq=16, res_sum_TxI=32.
3. line_valid high every other cycle, with I=3 and T=1 → still exactly 4 acc_en; res_sum_I=48, res_sum_I_sq=144, res_sum_TxI=48.
4. res_ready held low for 10 cycles after res_valid, with start pulsed during that time → res_* stable, line_ready=0, start ignored; res_valid drops the cycle after res_ready=1; state returns to IDLE.
5. abort after 2 accepted lines, then start with I=1 and T=2 → IDLE next cycle with no res_valid; the new window produces res_sum_I=16 and res_sum_TxI=32, including a fresh acc_clear.
6. reset driven low asynchronously mid-DRAIN, between clock edges → outputs 0 immediately; no res_valid after release until a new start completes a window.

Source files
------------

// File: rtl/tm_window_sequencer.sv
// Window-pass sequencer for the template-matching accumulator datapath:
// clears the sums, streams NUM_OF_LINES lines, drains the pipeline and hands off the results.
module tm_window_sequencer #(
    parameter int unsigned PIXEL_SIZE    = 8,
    parameter int unsigned LINE_SIZE     = 8,
    parameter int unsigned NUM_OF_LINES  = 8,
    parameter int unsigned NUM_TEMPLATES = 1,
    parameter int unsigned ACC_LATENCY   = 2,
    localparam int unsigned ACC_W = $clog2(NUM_OF_LINES) + $clog2(LINE_SIZE) + 2 * PIXEL_SIZE,
    localparam int unsigned IDX_W = (NUM_OF_LINES > 1) ? $clog2(NUM_OF_LINES) : 1
) (
    input  logic                             CLK,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    output logic                             busy,
    input  logic                             line_valid,
    output logic                             line_ready,
    output logic                             acc_clear,
    output logic                             acc_en,
    output logic [IDX_W-1:0]                 line_idx,
    input  logic [ACC_W-1:0]                 acc_sum_I,
    input  logic [ACC_W-1:0]                 acc_sum_I_sq,
    input  logic [ACC_W*NUM_TEMPLATES-1:0]   acc_sum_TxI,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [ACC_W-1:0]                 res_sum_I,
    output logic [ACC_W-1:0]                 res_sum_I_sq,
    output logic [ACC_W*NUM_TEMPLATES-1:0]   res_sum_TxI
);

    localparam int unsigned DRN_W = (ACC_LATENCY > 0) ? $clog2(ACC_LATENCY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_LINES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   line_cnt_q, line_cnt_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic               res_valid_d;
    logic               capture_c;
    logic               acc_en_c;

    // Next-state, counters and capture strobe; abort overrides everything outside IDLE.
    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        drain_cnt_d = drain_cnt_q;
        res_valid_d = res_valid;
        capture_c   = 1'b0;
        acc_en_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                line_cnt_d = '0;
                state_d    = STREAM;
            end
            STREAM: begin
                acc_en_c = line_valid & line_ready;
                if (acc_en_c) begin
                    if (line_cnt_q == LAST_IDX) begin
                        drain_cnt_d = DRN_W'(ACC_LATENCY);
                        state_d     = DRAIN;
                    end else begin
                        line_cnt_d = line_cnt_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    capture_c   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRN_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    line_cnt_d  = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            line_cnt_d  = '0;
            drain_cnt_d = '0;
            res_valid_d = 1'b0;
            capture_c   = 1'b0;
            acc_en_c    = 1'b0;
        end
    end

    // State, counters and registered status outputs decoded from the next state.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            line_cnt_q  <= '0;
            drain_cnt_q <= '0;
            busy        <= 1'b0;
            line_ready  <= 1'b0;
            acc_clear   <= 1'b0;
            res_valid   <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            busy        <= (state_d != IDLE);
            line_ready  <= (state_d == STREAM);
            acc_clear   <= (state_d == CLEAR);
            res_valid   <= res_valid_d;
        end
    end

    // Result capture: sums are taken verbatim and held until the next capture.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            res_sum_I    <= '0;
            res_sum_I_sq <= '0;
            res_sum_TxI  <= '0;
        end else if (capture_c) begin
            res_sum_I    <= acc_sum_I;
            res_sum_I_sq <= acc_sum_I_sq;
            res_sum_TxI  <= acc_sum_TxI;
        end
    end

    assign acc_en   = acc_en_c;
    assign line_idx = line_cnt_q;

endmodule
